// File: rtl/dbn_arb_pkg.sv
// Shared types and default sizes for the horizontal/vertical arbitration blocks.
// Index width is derived from the core count so encoders and servers agree.
package dbn_arb_pkg;

  localparam int NUM_CORE_H_DFLT = 6;
  localparam int DATA_W_DFLT     = 16;
  localparam int CNT_W_DFLT      = 16;
  localparam int IDX_W           = $clog2(NUM_CORE_H_DFLT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef logic [IDX_W-1:0] core_idx_t;

endpackage

// File: rtl/onehot_to_idx_hv.sv
// Combinational one-hot to binary encoder with one-hot and multi-hot flags.
// idx is only meaningful while valid is high.
module onehot_to_idx_hv
  import dbn_arb_pkg::*;
#(
  parameter int N  = NUM_CORE_H_DFLT,
  parameter int IW = IDX_W
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid,
  output logic          multi
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = idx | IW'(i);
    end
    valid = $onehot(vec);
    multi = (vec != '0) && !valid;
  end

endmodule

// File: rtl/arbiter_grant_server_hv.sv
// Responder for the horizontal arbiter: captures the granted core's word,
// forwards it with valid/ready, then pulses a per-core ack.
//
// state   | meaning
// IDLE    | waiting for a one-hot grant
// SEND    | out_valid high, holding captured word until out_ready
// ACK     | one-cycle core_ack pulse, served_cnt advances
// RELEASE | waiting for the served core to drop its grant bit
module arbiter_grant_server_hv
  import dbn_arb_pkg::*;
#(
  parameter int NUM_CORE_H = NUM_CORE_H_DFLT,
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CORE_H-1:0]        grant_in,
  input  logic [NUM_CORE_H*DATA_W-1:0] core_data,
  output logic [NUM_CORE_H-1:0]        core_ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output core_idx_t                    out_idx,
  output logic                         busy,
  output logic                         grant_err,
  output logic [CNT_W-1:0]             served_cnt
);

  state_t                  state, state_nxt;
  logic [NUM_CORE_H-1:0]   grant_q;
  core_idx_t               idx_q;
  core_idx_t               enc_idx;
  logic [DATA_W-1:0]       data_q;
  logic [DATA_W-1:0]       sel_word;
  logic                    enc_valid;
  logic                    enc_multi;
  logic                    capture;

  onehot_to_idx_hv #(
    .N  (NUM_CORE_H),
    .IW (IDX_W)
  ) u_enc (
    .vec   (grant_in),
    .idx   (enc_idx),
    .valid (enc_valid),
    .multi (enc_multi)
  );

  assign sel_word = core_data[enc_idx*DATA_W +: DATA_W];

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (enc_valid) begin
          state_nxt = SEND;
          capture   = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) state_nxt = ACK;
      end
      ACK: begin
        state_nxt = RELEASE;
      end
      RELEASE: begin
        // Served bit must drop first so a held request is never served twice
        if ((grant_in & grant_q) == '0) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      grant_err  <= 1'b0;
      served_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        grant_q <= grant_in;
        idx_q   <= enc_idx;
        data_q  <= sel_word;
      end
      if (state == IDLE && enc_multi) grant_err <= 1'b1;
      if (state == ACK) served_cnt <= served_cnt + CNT_W'(1);
    end
  end

  assign out_valid = (state == SEND);
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign busy      = (state != IDLE);
  assign core_ack  = (state == ACK) ? grant_q : '0;

endmodule

// File: tb/tb_arbiter_grant_server_hv.sv
// Directed bench for arbiter_grant_server_hv: vector table plus hand sequences
// for back-pressure, held request, mid-transfer reset and counter wrap.
module tb_arbiter_grant_server_hv;

  localparam int NC  = 6;
  localparam int DW  = 16;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     grant_in;
  logic [NC*DW-1:0]  core_data;
  logic [NC-1:0]     core_ack;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [2:0]        out_idx;
  logic              busy;
  logic              grant_err;
  logic [CW-1:0]     served_cnt;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt;
  logic [DW-1:0] exp_word [NC];

  arbiter_grant_server_hv #(
    .NUM_CORE_H (NC),
    .DATA_W     (DW),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .grant_in   (grant_in),
    .core_data  (core_data),
    .core_ack   (core_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .busy       (busy),
    .grant_err  (grant_err),
    .served_cnt (served_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] grant;
    logic          ready;
    logic          valid;
    logic [DW-1:0] data;
    logic [2:0]    idx;
    logic [NC-1:0] ack;
    logic          bsy;
    logic          err;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic [2:0] ix, input logic [NC-1:0] a, input logic b,
                         input logic e, input logic [CW-1:0] c);
    chk({tag, ".out_valid"},  32'(out_valid),  32'(v));
    chk({tag, ".out_data"},   32'(out_data),   32'(d));
    chk({tag, ".out_idx"},    32'(out_idx),    32'(ix));
    chk({tag, ".core_ack"},   32'(core_ack),   32'(a));
    chk({tag, ".busy"},       32'(busy),       32'(b));
    chk({tag, ".grant_err"},  32'(grant_err),  32'(e));
    chk({tag, ".served_cnt"}, 32'(served_cnt), 32'(c));
  endtask

  task automatic load_words();
    for (int i = 0; i < NC; i++) core_data[i*DW +: DW] = exp_word[i];
  endtask

  task automatic do_transfer(input int b);
    logic [NC-1:0] g;
    g = '0;
    g[b] = 1'b1;
    grant_in  = g;
    out_ready = 1'b1;
    tick();
    chk("xfer.valid", 32'(out_valid), 32'd1);
    chk("xfer.idx",   32'(out_idx),   32'(b));
    chk("xfer.data",  32'(out_data),  32'(exp_word[b]));
    tick();
    chk("xfer.ack",   32'(core_ack),  32'(g));
    grant_in = '0;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("xfer.cnt",   32'(served_cnt), 32'(exp_cnt));
    tick();
    chk("xfer.idle",  32'(busy),       32'd0);
  endtask

  initial begin
    exp_word[0] = 16'h1111; exp_word[1] = 16'h2222; exp_word[2] = 16'h3333;
    exp_word[3] = 16'hA5A5; exp_word[4] = 16'h5555; exp_word[5] = 16'h6666;

    //            grant      rdy   vld   data      idx   ack        bsy   err   cnt
    tbl[0]  = '{6'b000000, 1'b1, 1'b0, 16'h0000, 3'd0, 6'b000000, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{6'b001000, 1'b1, 1'b1, 16'hA5A5, 3'd3, 6'b000000, 1'b1, 1'b0, 4'd0};
    tbl[2]  = '{6'b001000, 1'b1, 1'b0, 16'hA5A5, 3'd3, 6'b001000, 1'b1, 1'b0, 4'd0};
    tbl[3]  = '{6'b001000, 1'b1, 1'b0, 16'hA5A5, 3'd3, 6'b000000, 1'b1, 1'b0, 4'd1};
    tbl[4]  = '{6'b001000, 1'b1, 1'b0, 16'hA5A5, 3'd3, 6'b000000, 1'b1, 1'b0, 4'd1};
    tbl[5]  = '{6'b000100, 1'b1, 1'b0, 16'hA5A5, 3'd3, 6'b000000, 1'b0, 1'b0, 4'd1};
    tbl[6]  = '{6'b000100, 1'b0, 1'b1, 16'h3333, 3'd2, 6'b000000, 1'b1, 1'b0, 4'd1};
    tbl[7]  = '{6'b000100, 1'b0, 1'b1, 16'h3333, 3'd2, 6'b000000, 1'b1, 1'b0, 4'd1};
    tbl[8]  = '{6'b000100, 1'b1, 1'b0, 16'h3333, 3'd2, 6'b000100, 1'b1, 1'b0, 4'd1};
    tbl[9]  = '{6'b000000, 1'b1, 1'b0, 16'h3333, 3'd2, 6'b000000, 1'b1, 1'b0, 4'd2};
    tbl[10] = '{6'b000000, 1'b1, 1'b0, 16'h3333, 3'd2, 6'b000000, 1'b0, 1'b0, 4'd2};
    tbl[11] = '{6'b010010, 1'b1, 1'b0, 16'h3333, 3'd2, 6'b000000, 1'b0, 1'b1, 4'd2};
    tbl[12] = '{6'b000001, 1'b1, 1'b1, 16'h1111, 3'd0, 6'b000000, 1'b1, 1'b1, 4'd2};
    tbl[13] = '{6'b000001, 1'b1, 1'b0, 16'h1111, 3'd0, 6'b000001, 1'b1, 1'b1, 4'd2};
    tbl[14] = '{6'b000000, 1'b1, 1'b0, 16'h1111, 3'd0, 6'b000000, 1'b1, 1'b1, 4'd3};
    tbl[15] = '{6'b000000, 1'b1, 1'b0, 16'h1111, 3'd0, 6'b000000, 1'b0, 1'b1, 4'd3};

    rst_n     = 1'b0;
    grant_in  = '0;
    out_ready = 1'b0;
    load_words();
    tick();
    tick();
    chk_all("reset", 1'b0, 16'h0, 3'd0, '0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;

    for (int r = 0; r < 16; r++) begin
      grant_in  = tbl[r].grant;
      out_ready = tbl[r].ready;
      tick();
      chk_all($sformatf("vec%0d", r), tbl[r].valid, tbl[r].data, tbl[r].idx,
              tbl[r].ack, tbl[r].bsy, tbl[r].err, tbl[r].cnt);
    end
    exp_cnt = 4'd3;

    // Back-pressure: captured word must hold while core 0 keeps changing
    core_data[0 +: DW] = 16'h0BEE;
    grant_in  = 6'b000001;
    out_ready = 1'b0;
    tick();
    chk("bp.first_valid", 32'(out_valid), 32'd1);
    chk("bp.first_data",  32'(out_data),  32'h0BEE);
    for (int k = 0; k < 5; k++) begin
      core_data[0 +: DW] = 16'hF000 | 16'(k);
      grant_in = (k % 2 == 0) ? 6'b000011 : 6'b000001;
      tick();
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_data",  32'(out_data),  32'h0BEE);
      chk("bp.hold_idx",   32'(out_idx),   32'd0);
      chk("bp.no_ack",     32'(core_ack),  32'd0);
    end
    grant_in  = 6'b000001;
    out_ready = 1'b1;
    tick();
    chk("bp.ack", 32'(core_ack), 32'b000001);
    chk("bp.ack_valid_low", 32'(out_valid), 32'd0);
    grant_in = '0;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("bp.cnt", 32'(served_cnt), 32'(exp_cnt));
    tick();
    chk("bp.idle", 32'(busy), 32'd0);
    load_words();

    // Held request on core 5 must be served exactly once
    grant_in = 6'b100000;
    tick();
    chk("held.idx",  32'(out_idx),  32'd5);
    chk("held.data", 32'(out_data), 32'h6666);
    tick();
    chk("held.ack",  32'(core_ack), 32'b100000);
    exp_cnt = exp_cnt + 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("held.no_valid", 32'(out_valid), 32'd0);
      chk("held.no_ack",   32'(core_ack),  32'd0);
      chk("held.busy",     32'(busy),      32'd1);
      chk("held.cnt",      32'(served_cnt), 32'(exp_cnt));
    end
    grant_in = 6'b000010;
    tick();
    chk("held.release_idle", 32'(busy), 32'd0);
    tick();
    chk("held.second_valid", 32'(out_valid), 32'd1);
    chk("held.second_idx",   32'(out_idx),   32'd1);
    chk("held.second_data",  32'(out_data),  32'h2222);
    tick();
    chk("held.second_ack",   32'(core_ack),  32'b000010);
    grant_in = '0;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("held.cnt2", 32'(served_cnt), 32'(exp_cnt));
    tick();

    // Reset while SEND discards the transfer
    grant_in  = 6'b000100;
    out_ready = 1'b0;
    tick();
    chk("rst.pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk_all("rst.mid", 1'b0, 16'h0, 3'd0, '0, 1'b0, 1'b0, 4'd0);
    rst_n    = 1'b1;
    grant_in = '0;
    out_ready = 1'b1;
    tick();
    chk_all("rst.after", 1'b0, 16'h0, 3'd0, '0, 1'b0, 1'b0, 4'd0);
    exp_cnt = '0;

    // Counter wrap at 2^CW transfers
    for (int t = 0; t < 15; t++) do_transfer(t % NC);
    chk("wrap.full", 32'(served_cnt), 32'd15);
    do_transfer(4);
    chk("wrap.zero", 32'(served_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
